// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared FSM state, status-word bit positions and beat sizing for debug_txn_capture
package debug_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int BYTES_PER_BEAT = 8;

  localparam int NB_LSB      = 0;
  localparam int REM_LSB     = 32;
  localparam int CNT_LSB     = 48;
  localparam int STRAY_BIT   = 59;
  localparam int BUSY_BIT    = 60;
  localparam int OVERRUN_BIT = 61;
  localparam int TIMEOUT_BIT = 62;
  localparam int DONE_BIT    = 63;

  // ceil(nbytes / BYTES_PER_BEAT), saturated to the 16-bit remaining-beats field
  function automatic logic [15:0] beats_for(input logic [31:0] nbytes);
    logic [32:0] beats;
    beats = ({1'b0, nbytes} + 33'(BYTES_PER_BEAT - 1)) / 33'(BYTES_PER_BEAT);
    return (beats > 33'd65535) ? 16'hFFFF : beats[15:0];
  endfunction

endpackage

// File: rtl/debug_watchdog.sv
// rtl/debug_watchdog.sv - beatless-cycle counter that flags a stalled burst (built only with DBG_TIMEOUT_EN)
module debug_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic beat_i,
  output logic expired_o
);

  logic [15:0] cnt_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive beatless cycle in BURST
  assign expired_o = active_i && !beat_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!active_i || beat_i || expired_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/debug_txn_capture.sv
// rtl/debug_txn_capture.sv - passive request/data-beat observer feeding the ILA probes; DBG_TIMEOUT_EN adds a burst watchdog
module debug_txn_capture
  import debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        v_clk0,
  input  logic        v_rst0,
  input  logic        req_valid,
  input  logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [31:0] req_nbytes,
  input  logic        dat_valid,
  input  logic        dat_ready,
  input  logic [63:0] dat_data,
  output logic [63:0] dbg_addr,
  output logic [63:0] dbg_nbytes,
  output logic [63:0] dbg_data
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  state_e      state_q;
  logic [63:0] addr_q;
  logic [31:0] nbytes_q;
  logic [15:0] beats_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [63:0] data_q;
  logic        stray_q;
  logic        overrun_q;
  logic        done_q;
  logic        timeout_flag;
  logic        timeout_hit;

  logic hs, beat, busy, final_beat, accept, zero_req;

  assign hs         = req_valid && req_ready;
  assign beat       = dat_valid && dat_ready;
  assign busy       = (state_q == ST_BURST);
  assign final_beat = busy && beat && (beats_q == 16'd1);
  assign accept     = hs && (!busy || final_beat);
  assign zero_req   = (req_nbytes == 32'd0);
  // A zero-length request landing on the final beat completes two transactions at once
  assign cnt_d      = cnt_q + 8'(final_beat) + 8'(accept && zero_req);

`ifdef DBG_TIMEOUT_EN
  logic timeout_q;

  debug_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (v_clk0),
    .rst_i     (v_rst0),
    .active_i  (busy),
    .beat_i    (beat),
    .expired_o (timeout_hit)
  );

  always_ff @(posedge v_clk0 or posedge v_rst0) begin
    if (v_rst0) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge v_clk0 or posedge v_rst0) begin
    if (v_rst0) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      nbytes_q  <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      stray_q   <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= final_beat || (accept && zero_req);
      cnt_q  <= cnt_d;
      if (beat) begin
        data_q <= dat_data;
        if (!busy) stray_q <= 1'b1;
      end
      if (hs && busy && !final_beat) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: ;
        ST_BURST: begin
          if (beat) begin
            beats_q <= beats_q - 16'd1;
            if (final_beat) state_q <= ST_IDLE;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Accepted request overrides the completion above when both happen together
      if (accept) begin
        addr_q   <= req_addr;
        nbytes_q <= req_nbytes;
        beats_q  <= beats_for(req_nbytes);
        state_q  <= zero_req ? ST_IDLE : ST_BURST;
      end
    end
  end

  always_comb begin
    dbg_nbytes                               = '0;
    dbg_nbytes[NB_LSB +: 32]                 = nbytes_q;
    dbg_nbytes[REM_LSB +: 16]                = beats_q;
    dbg_nbytes[CNT_LSB +: 8]                 = cnt_q;
    dbg_nbytes[STRAY_BIT]                    = stray_q;
    dbg_nbytes[BUSY_BIT]                     = busy;
    dbg_nbytes[OVERRUN_BIT]                  = overrun_q;
    dbg_nbytes[TIMEOUT_BIT]                  = timeout_flag;
    dbg_nbytes[DONE_BIT]                     = done_q;
  end

  assign dbg_addr = addr_q;
  assign dbg_data = data_q;

endmodule

// File: tb/tb_debug_txn_capture.sv
// tb/tb_debug_txn_capture.sv - randomized scoreboard bench for debug_txn_capture against a behavioural model
module tb_debug_txn_capture;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready = 1'b0;
  logic [63:0] req_addr = '0;
  logic [31:0] req_nbytes = '0;
  logic        dat_valid = 1'b0, dat_ready = 1'b0;
  logic [63:0] dat_data = '0;
  logic [63:0] dbg_addr, dbg_nbytes, dbg_data;

  debug_txn_capture #(.TIMEOUT_CYCLES(TMO)) dut (
    .v_clk0     (clk),
    .v_rst0     (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_nbytes (req_nbytes),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dat_data   (dat_data),
    .dbg_addr   (dbg_addr),
    .dbg_nbytes (dbg_nbytes),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] status;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference state
  bit          m_burst, m_stray, m_over, m_tmo, m_done;
  int          m_rem, m_cnt, m_idle;
  logic [63:0] m_addr, m_data;
  logic [31:0] m_nb;

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s = 64'(m_nb);
    s = s | (64'(m_rem) << 32) | (64'(m_cnt) << 48);
    s = s | (64'(m_stray) << 59) | (64'(m_burst) << 60) | (64'(m_over) << 61);
    s = s | (64'(m_tmo) << 62) | (64'(m_done) << 63);
    return s;
  endfunction

  task automatic m_clear();
    m_burst = 0; m_stray = 0; m_over = 0; m_tmo = 0; m_done = 0;
    m_rem = 0; m_cnt = 0; m_idle = 0; m_addr = '0; m_data = '0; m_nb = '0;
  endtask

  task automatic m_accept(input logic [63:0] a, input logic [31:0] nb);
    longint beats;
    m_addr = a;
    m_nb   = nb;
    beats  = (longint'(nb) + 7) / 8;
    m_rem  = (beats > 65535) ? 65535 : int'(beats);
    if (nb == 0) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_done = 1;
    end else begin
      m_burst = 1;
      m_idle  = 0;
    end
  endtask

  task automatic cycle(input bit rv, input bit rr, input logic [63:0] a, input logic [31:0] nb,
                       input bit dv, input bit dr, input logic [63:0] d);
    bit hs, bt;
    exp_t e;
    @(negedge clk);
    req_valid = rv; req_ready = rr; req_addr = a; req_nbytes = nb;
    dat_valid = dv; dat_ready = dr; dat_data = d;
    hs = rv && rr;
    bt = dv && dr;
    m_done = 0;
    if (bt) begin
      m_data = d;
      if (!m_burst) m_stray = 1;
    end
    if (m_burst) begin
      if (bt) begin
        m_rem  = m_rem - 1;
        m_idle = 0;
        if (m_rem == 0) begin
          m_burst = 0;
          m_cnt   = (m_cnt + 1) % 256;
          m_done  = 1;
          if (hs) m_accept(a, nb);
        end else if (hs) begin
          m_over = 1;
        end
      end else begin
        if (hs) m_over = 1;
`ifdef DBG_TIMEOUT_EN
        m_idle = m_idle + 1;
        if (m_idle == TMO) begin
          m_burst = 0;
          m_tmo   = 1;
        end
`endif
      end
    end else if (hs) begin
      m_accept(a, nb);
    end
    e.addr = m_addr; e.status = m_status(); e.data = m_data;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic req(input logic [63:0] a, input logic [31:0] nb);
    cycle(1, 1, a, nb, 0, 0, '0);
  endtask

  task automatic beat(input logic [63:0] d);
    cycle(0, 0, '0, '0, 1, 1, d);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (dbg_addr !== '0 || dbg_nbytes !== '0 || dbg_data !== '0) begin
      miscompares++;
      $display("FAIL %s: got addr=%h status=%h data=%h, want all zero", name, dbg_addr, dbg_nbytes, dbg_data);
    end
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge
  task automatic do_reset(input string name);
    @(negedge clk);
    req_valid = 0; dat_valid = 0;
    #2 rst = 1'b1;
    #1 check_zero(name);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: DUT presents a fresh output set after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (dbg_addr !== e.addr || dbg_nbytes !== e.status || dbg_data !== e.data) begin
          miscompares++;
          $display("FAIL outputs @%0t: got addr=%h status=%h data=%h, want addr=%h status=%h data=%h",
                   $time, dbg_addr, dbg_nbytes, dbg_data, e.addr, e.status, e.data);
        end
      end
    end
  end

  initial begin
    int wait_budget;
    m_clear();
    #1 check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Basic 3-beat burst
    req(64'h1000, 32'd24);
    beat(64'hA); beat(64'hB); beat(64'hC);
    idle_cycles(2);

    // Zero-length request
    req(64'h2000, 32'd0);
    idle_cycles(2);

    // Stray beat in IDLE
    beat(64'hDEAD_BEEF);
    idle_cycles(1);

    // Request mid-burst is ignored and sets overrun
    req(64'h3000, 32'd16);
    req(64'h4000, 32'd8);
    beat(64'h1); beat(64'h2);
    idle_cycles(1);

    // Request on the final-beat cycle is accepted without overrun
    do_reset("reset_before_final_beat_req");
    req(64'h5000, 32'd16);
    beat(64'h11);
    cycle(1, 1, 64'h6000, 32'd9, 1, 1, 64'h22);
    beat(64'h33); beat(64'h44);
    cycle(1, 1, 64'h7000, 32'd0, 1, 1, 64'h55);
    req(64'h7100, 32'd8);
    cycle(1, 1, 64'h7200, 32'd0, 1, 1, 64'h66);
    idle_cycles(2);

    // Stalled burst: watchdog or indefinite wait
    req(64'h8000, 32'd64);
`ifdef DBG_TIMEOUT_EN
    idle_cycles(TMO + 4);
`else
    idle_cycles(1000);
`endif

    // Saturating beat count, then reset mid-burst
    do_reset("reset_after_stall");
    req(64'h9000, 32'hFFFF_FFF0);
    beat(64'h77);
    do_reset("reset_mid_burst");

    // 256 completed transactions wrap the count
    for (int i = 0; i < 256; i++) req(64'(i), 32'd0);
    req(64'hA000, 32'd1);
    beat(64'h88);
    idle_cycles(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] nb;
      int pick;
      if (n % 600 == 599) do_reset("reset_random");
      pick = int'($urandom % 10);
      if (pick == 0)      nb = 32'd0;
      else if (pick == 1) nb = $urandom;
      else                nb = 32'($urandom_range(1, 64));
      cycle(($urandom % 6) == 0, ($urandom % 2) == 0, {$urandom, $urandom}, nb,
            ($urandom % 2) == 0, ($urandom % 4) != 0, {$urandom, $urandom});
    end
    idle_cycles(2);

    wait_budget = 10;
    while (exp_q.size() > 0 && wait_budget > 0) begin
      @(negedge clk);
      wait_budget--;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
